// File: rtl/tach_status_ctrl.sv
// rtl/tach_status_ctrl.sv - tach count-enable prescaler, sticky capture status and masked interrupt
//
// Parameters:
//   TACH_NUM       number of tachometer channels served (1..16)
// Configuration macro:
//   TACH_PRESCALE_EN  defined: build the 10-bit prescaler driven by prescale_sel
//                     undefined: tach_cnt_clk held at 1 after reset, prescale_sel unused
// Ports:
//   PCLK           system clock, rising edge
//   PRESETN        asynchronous active-low reset
//   prescale_sel   count-enable divide select, divide by 2^prescale_sel (11..15 clamp to 10)
//   update_status  per-channel capture-complete level from each tach channel
//   status_wr      single-cycle write strobe to the status register
//   status_wdata   write-1-to-clear data, bit i clears channel i
//   irq_mask       per-channel interrupt enable
//   tach_cnt_clk   one-PCLK count-enable pulse to all tach channels
//   TACHSTATUS     sticky per-channel capture status
//   status_clear   per-channel "status clear, capture allowed" (~TACHSTATUS)
//   TACHINT        registered OR of masked status bits

module tach_status_ctrl #(
    parameter int TACH_NUM = 1
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic [3:0]          prescale_sel,
    input  logic [TACH_NUM-1:0] update_status,
    input  logic                status_wr,
    input  logic [15:0]         status_wdata,
    input  logic [15:0]         irq_mask,
    output logic                tach_cnt_clk,
    output logic [TACH_NUM-1:0] TACHSTATUS,
    output logic [TACH_NUM-1:0] status_clear,
    output logic                TACHINT
);

`ifdef TACH_PRESCALE_EN
    logic [3:0] sel_q;
    logic [9:0] cnt;
    logic [3:0] sel_eff;
    logic [9:0] reload;

    always_comb begin
        sel_eff = (prescale_sel > 4'd10) ? 4'd10 : prescale_sel;
        reload  = 10'((11'd1 << sel_eff) - 11'd1);
    end

    // Reaching zero always pulses (this is what gives the first pulse right
    // after reset). A select change mid-count restarts the count silently so
    // the first pulse at the new rate lands a full new period later.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sel_q        <= 4'd0;
            cnt          <= 10'd0;
            tach_cnt_clk <= 1'b0;
        end else if (cnt == 10'd0) begin
            sel_q        <= prescale_sel;
            cnt          <= reload;
            tach_cnt_clk <= 1'b1;
        end else if (sel_q != prescale_sel) begin
            sel_q        <= prescale_sel;
            cnt          <= reload;
            tach_cnt_clk <= 1'b0;
        end else begin
            cnt          <= cnt - 10'd1;
            tach_cnt_clk <= 1'b0;
        end
    end
`else
    logic unused_prescale_sel;
    assign unused_prescale_sel = ^prescale_sel;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tach_cnt_clk <= 1'b0;
        end else begin
            tach_cnt_clk <= 1'b1;
        end
    end
`endif

    // Only the low TACH_NUM bits of the write data and mask are meaningful.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{status_wdata, irq_mask};

    logic [TACH_NUM-1:0] upd_q;
    logic                hist_valid;
    logic [TACH_NUM-1:0] rise;
    logic [TACH_NUM-1:0] clr;

    // hist_valid masks the first cycle after reset so a level already high
    // across reset release is not mistaken for a fresh capture edge.
    always_comb begin
        rise = hist_valid ? (update_status & ~upd_q) : '0;
        clr  = status_wr ? status_wdata[TACH_NUM-1:0] : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            upd_q      <= '0;
            hist_valid <= 1'b0;
            TACHSTATUS <= '0;
            TACHINT    <= 1'b0;
        end else begin
            upd_q      <= update_status;
            hist_valid <= 1'b1;
            // set after clear: a same-cycle edge wins over the write
            TACHSTATUS <= (TACHSTATUS & ~clr) | rise;
            TACHINT    <= |(TACHSTATUS & irq_mask[TACH_NUM-1:0]);
        end
    end

    assign status_clear = ~TACHSTATUS;

endmodule
